// File: rtl/alu_pkg.sv
// Shared definitions for the ALU share arbiter: ALUsel codes, FSM encoding and
// the overflow-qualifying op helper.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'h2;
  localparam logic [3:0] ALU_SUB = 4'h6;
  localparam logic [3:0] ALU_SLT = 4'h7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Only the signed arithmetic ops can meaningfully overflow.
  function automatic logic is_ovf_op(input logic [3:0] sel);
    return (sel == ALU_ADD) || (sel == ALU_SUB) || (sel == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// Round-robin winner select: first valid requester at or above ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [1:0]      idx,
  output logic            any
);

  always_comb begin
    int i;
    i     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      i = (int'(ptr) + k) % NREQ;
      if (!any && req_valid[i]) begin
        grant[i] = 1'b1;
        idx      = 2'(i);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU/overflow detector among NREQ
// requesters. Optional sticky overflow flags under `ALU_OVF_STICKY_EN.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_op,
  input  logic [DW*NREQ-1:0] req_a,
  input  logic [DW*NREQ-1:0] req_b,
`ifdef ALU_OVF_STICKY_EN
  output logic [NREQ-1:0]   ovf_sticky,
  input  logic [NREQ-1:0]   ovf_clr,
`endif
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [1:0]        resp_id,
  output logic [DW-1:0]     resp_res,
  output logic              resp_ovf,
  output logic [3:0]        alu_sel,
  output logic [DW-1:0]     alu_a,
  output logic [DW-1:0]     alu_b,
  input  logic [DW-1:0]     alu_res,
  input  logic              alu_ovf
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_inc;
  logic [NREQ-1:0]    grant;
  logic [1:0]         win_idx;
  logic               win_any;
  logic               accept, resp_hs;

  logic [3:0]         op_p0;
  logic [DW-1:0]      a_p0, b_p0;
  logic [1:0]         gid_p0;
  logic [DW-1:0]      res_p1;
  logic               ovf_p1;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_rr_pick (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .idx       (win_idx),
    .any       (win_any)
  );

  assign accept  = (state_q == ST_IDLE) && win_any;
  assign resp_hs = (state_q == ST_RESP) && resp_ready;

  always_comb begin
    if (int'(gid_p0) >= NREQ - 1) ptr_inc = '0;
    else                          ptr_inc = PW'(gid_p0 + 2'd1);
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    resp_valid = 1'b0;
    alu_sel    = 4'h0;
    alu_a      = '0;
    alu_b      = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = grant;
        if (win_any) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        alu_sel = op_p0;
        alu_a   = a_p0;
        alu_b   = b_p0;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (resp_hs) ptr_q <= ptr_inc;
    end
  end

  // p0: operands latched on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_p0  <= 4'h0;
      a_p0   <= '0;
      b_p0   <= '0;
      gid_p0 <= '0;
    end else if (accept) begin
      op_p0  <= req_op[4*win_idx +: 4];
      a_p0   <= req_a[DW*win_idx +: DW];
      b_p0   <= req_b[DW*win_idx +: DW];
      gid_p0 <= win_idx;
    end
  end

  // p1: ALU outputs captured at the end of EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_p1 <= '0;
      ovf_p1 <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      res_p1 <= alu_res;
      ovf_p1 <= alu_ovf & is_ovf_op(op_p0);
    end
  end

  assign resp_id  = gid_p0;
  assign resp_res = res_p1;
  assign resp_ovf = ovf_p1;

`ifdef ALU_OVF_STICKY_EN
  logic [NREQ-1:0] sticky_q, sticky_set;

  assign sticky_set = (resp_hs && ovf_p1) ? (NREQ'(1) << gid_p0) : '0;

  // Set takes priority over a clear landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= '0;
    else        sticky_q <= sticky_set | (sticky_q & ~ovf_clr);
  end

  assign ovf_sticky = sticky_q;
`endif

endmodule
